// File: rtl/mb_scheduler.sv
// Raster-order macroblock scheduler: issues one extractor enable per MB, waits out the
// extractor latency, then presents the MB to intra-prediction over valid/ready.
module mb_scheduler #(
   parameter int unsigned WIDTH       = 1280,
   parameter int unsigned LENGTH      = 720,
   parameter int unsigned MB_SIZE_L   = 16,
   parameter int unsigned MB_SIZE_W   = 16,
   parameter int unsigned EXTRACT_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   output logic        ext_enable,
   output logic [31:0] mbnumber,
   output logic        mb_valid,
   input  logic        mb_ready,
   output logic        mb_first,
   output logic        mb_last,
   output logic [31:0] mb_index,
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned CNT_W = (EXTRACT_LAT > 1) ? $clog2(EXTRACT_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXTRACT_LAT - 1);
   localparam logic [15:0] LAST_ROW = 16'(LENGTH - MB_SIZE_L);
   localparam logic [15:0] LAST_COL = 16'(WIDTH - MB_SIZE_W);
   localparam logic [15:0] STEP_ROW = 16'(MB_SIZE_L);
   localparam logic [15:0] STEP_COL = 16'(MB_SIZE_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       row_q, row_d;
   logic [15:0]       col_q, col_d;
   logic [31:0]       idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ext_enable_d, mb_valid_d, mb_first_d, mb_last_d, busy_d, frame_done_d;
   logic              cur_last;

   assign mbnumber = {row_q, col_q};
   assign cur_last = (row_q == LAST_ROW) && (col_q == LAST_COL);

   // State register plus registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         row_q      <= '0;
         col_q      <= '0;
         mb_index   <= '0;
         cnt_q      <= '0;
         ext_enable <= 1'b0;
         mb_valid   <= 1'b0;
         mb_first   <= 1'b0;
         mb_last    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         mb_index   <= idx_d;
         cnt_q      <= cnt_d;
         ext_enable <= ext_enable_d;
         mb_valid   <= mb_valid_d;
         mb_first   <= mb_first_d;
         mb_last    <= mb_last_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
      end
   end

   // Next state, coordinate walk, and output values for the next cycle
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      idx_d        = mb_index;
      cnt_d        = cnt_q;
      ext_enable_d = 1'b0;
      mb_valid_d   = 1'b0;
      mb_first_d   = 1'b0;
      mb_last_d    = 1'b0;
      busy_d       = 1'b0;
      frame_done_d = 1'b0;

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         row_d   = '0;
         col_d   = '0;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_d = S_ISSUE;
                  row_d   = '0;
                  col_d   = '0;
                  idx_d   = '0;
               end
            end
            S_ISSUE: begin
               state_d = S_WAIT;
               cnt_d   = CNT_LOAD;
            end
            S_WAIT: begin
               if (cnt_q == '0) state_d = S_PRESENT;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_PRESENT: begin
               if (mb_ready) begin
                  if (cur_last) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                     idx_d   = mb_index + 32'd1;
                     if (col_q == LAST_COL) begin
                        col_d = '0;
                        row_d = row_q + STEP_ROW;
                     end else begin
                        col_d = col_q + STEP_COL;
                     end
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      busy_d       = (state_d != S_IDLE);
      ext_enable_d = (state_d == S_ISSUE);
      mb_valid_d   = (state_d == S_PRESENT);
      frame_done_d = (state_d == S_DONE);
      mb_first_d   = mb_valid_d && (idx_d == 32'd0);
      mb_last_d    = mb_valid_d && (row_d == LAST_ROW) && (col_d == LAST_COL);
   end

endmodule
